// File: rtl/lsu_issue_queue_param.sv
// lsu_issue_queue_param
//   Collapsing, age-ordered issue queue between dispatch and the LSU pipe.
//   Slot 0 always holds the oldest entry; valid entries are contiguous in
//   slots 0..count-1. Source readiness is tracked by snooping wakeup tag
//   broadcasts. The oldest eligible entry issues combinationally each cycle.
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   flush               synchronous clear of all entries (overflow kept)
//   enq_*               two dispatch channels, channel 0 older than channel 1
//   enq_ready           space for a double enqueue (count <= DEPTH-2)
//   wake_valid/tag      WAKE_N wakeup broadcast ports
//   lsu_busy            blocks issue
//   issue_valid/payload/idx  selected entry, dequeued at the next edge
//   count               occupied entries
//   overflow            sticky: an enqueue was presented while not ready
module lsu_issue_queue_param #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PRF_W      = 6,
    parameter int unsigned PAYLOAD_W  = 64,
    parameter int unsigned WAKE_N     = 4,
    parameter int unsigned ORDER_MODE = 1,
    localparam int unsigned IDX_W     = $clog2(DEPTH),
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [1:0]                enq_valid,
    input  logic [2*PAYLOAD_W-1:0]    enq_payload,
    input  logic [2*PRF_W-1:0]        enq_src0,
    input  logic [2*PRF_W-1:0]        enq_src1,
    input  logic [1:0]                enq_src0_rdy,
    input  logic [1:0]                enq_src1_rdy,
    input  logic [1:0]                enq_is_store,
    output logic                      enq_ready,
    input  logic [WAKE_N-1:0]         wake_valid,
    input  logic [WAKE_N*PRF_W-1:0]   wake_tag,
    input  logic                      lsu_busy,
    output logic                      issue_valid,
    output logic [PAYLOAD_W-1:0]      issue_payload,
    output logic [IDX_W-1:0]          issue_idx,
    output logic [CNT_W-1:0]          count,
    output logic                      overflow
);

    logic [DEPTH-1:0]     valid_q, store_q, rdy0_q, rdy1_q;
    logic [PRF_W-1:0]     src0_q    [DEPTH];
    logic [PRF_W-1:0]     src1_q    [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [CNT_W-1:0]     count_q;
    logic                 overflow_q;

    logic [DEPTH-1:0]     n_valid, n_store, n_rdy0, n_rdy1;
    logic [PRF_W-1:0]     n_src0    [DEPTH];
    logic [PRF_W-1:0]     n_src1    [DEPTH];
    logic [PAYLOAD_W-1:0] n_payload [DEPTH];
    logic [CNT_W-1:0]     n_count;
    logic                 n_overflow;

    logic [DEPTH-1:0]     rdy0_w, rdy1_w;
    logic                 sel_found, older_store, order_ok;
    logic [IDX_W-1:0]     sel_idx;
    logic                 do_enq;
    logic [1:0]           acc;
    logic [CNT_W-1:0]     base;
    logic [CNT_W-1:0]     enq_slot [2];
    int unsigned          src;

    function automatic logic wake_hit(input logic [PRF_W-1:0]        tag,
                                      input logic [WAKE_N-1:0]       wv,
                                      input logic [WAKE_N*PRF_W-1:0] wt);
        logic hit;
        hit = 1'b0;
        for (int unsigned w = 0; w < WAKE_N; w++)
            hit = hit | (wv[w] & (wt[w*PRF_W +: PRF_W] == tag));
        return hit;
    endfunction

    // Readiness including this cycle's wakeups; only used for the next state,
    // so a woken entry becomes eligible one cycle after the broadcast.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rdy0_w[i] = rdy0_q[i] | wake_hit(src0_q[i], wake_valid, wake_tag);
            rdy1_w[i] = rdy1_q[i] | wake_hit(src1_q[i], wake_valid, wake_tag);
        end
    end

    // Oldest-first select. In mode 1 an entry is blocked only by a valid
    // store strictly older than it, so a store may still pass older loads.
    always_comb begin
        sel_found   = 1'b0;
        sel_idx     = '0;
        older_store = 1'b0;
        order_ok    = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            order_ok = (ORDER_MODE == 0) ? (i == 0) : ~older_store;
            if (!sel_found && valid_q[i] && rdy0_q[i] && rdy1_q[i] && order_ok) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            older_store = older_store | (valid_q[i] & store_q[i]);
        end
        issue_valid   = sel_found & ~lsu_busy;
        issue_idx     = issue_valid ? sel_idx : '0;
        issue_payload = issue_valid ? payload_q[sel_idx] : '0;
    end

    assign enq_ready = (count_q <= CNT_W'(DEPTH - 2));
    assign count     = count_q;
    assign overflow  = overflow_q;

    // Next state: survivors collapse over the issued slot, then accepted
    // enqueues are packed directly behind them.
    always_comb begin
        do_enq      = enq_ready & ~flush;
        acc         = enq_valid & {2{do_enq}};
        base        = count_q - CNT_W'(issue_valid);
        enq_slot[0] = base;
        enq_slot[1] = base + CNT_W'(acc[0]);
        n_count     = base + CNT_W'(acc[0]) + CNT_W'(acc[1]);
        n_overflow  = overflow_q | ((|enq_valid) & ~enq_ready & ~flush);
        n_valid     = '0;
        n_store     = '0;
        n_rdy0      = '0;
        n_rdy1      = '0;
        src         = 0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            n_src0[i]    = '0;
            n_src1[i]    = '0;
            n_payload[i] = '0;
            src = (issue_valid && (i >= 32'(issue_idx))) ? i + 1 : i;
            if (src < 32'(count_q)) begin
                n_valid[i]   = 1'b1;
                n_store[i]   = store_q[IDX_W'(src)];
                n_rdy0[i]    = rdy0_w[IDX_W'(src)];
                n_rdy1[i]    = rdy1_w[IDX_W'(src)];
                n_src0[i]    = src0_q[IDX_W'(src)];
                n_src1[i]    = src1_q[IDX_W'(src)];
                n_payload[i] = payload_q[IDX_W'(src)];
            end
            for (int unsigned c = 0; c < 2; c++) begin
                if (acc[c] && (32'(enq_slot[c]) == i)) begin
                    n_valid[i]   = 1'b1;
                    n_store[i]   = enq_is_store[c];
                    n_src0[i]    = enq_src0[c*PRF_W +: PRF_W];
                    n_src1[i]    = enq_src1[c*PRF_W +: PRF_W];
                    n_rdy0[i]    = enq_src0_rdy[c] |
                                   wake_hit(enq_src0[c*PRF_W +: PRF_W], wake_valid, wake_tag);
                    n_rdy1[i]    = enq_src1_rdy[c] |
                                   wake_hit(enq_src1[c*PRF_W +: PRF_W], wake_valid, wake_tag);
                    n_payload[i] = enq_payload[c*PAYLOAD_W +: PAYLOAD_W];
                end
            end
        end
        if (flush) begin
            n_valid = '0;
            n_count = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            store_q    <= '0;
            rdy0_q     <= '0;
            rdy1_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                src0_q[i]    <= '0;
                src1_q[i]    <= '0;
                payload_q[i] <= '0;
            end
        end else begin
            valid_q    <= n_valid;
            store_q    <= n_store;
            rdy0_q     <= n_rdy0;
            rdy1_q     <= n_rdy1;
            count_q    <= n_count;
            overflow_q <= n_overflow;
            src0_q     <= n_src0;
            src1_q     <= n_src1;
            payload_q  <= n_payload;
        end
    end

endmodule
